// File: rtl/mastermind_game_ctrl.sv
// Purpose: sequencing FSM for the Mastermind datapath (digit loads, peg compare, judge, win/lose).
// Latency: 4th guess press at T -> clear_score T+1, compare_en T+2..T+5, result_valid T+6.
// Backpressure: none; key presses arriving while the compare sequence runs are dropped, not queued.
module mastermind_game_ctrl #(
    parameter int MAX_GUESSES = 8,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [2:0]       red_in,
    input  logic [2:0]       white_in,
    output logic [3:0]       load_code,
    output logic [3:0]       load_guess,
    output logic             clear_score,
    output logic             compare_en,
    output logic [1:0]       compare_i,
    output logic             hide_code,
    output logic             result_valid,
    output logic [CNT_W-1:0] guess_count,
    output logic             won,
    output logic             lost
);

    typedef enum logic [2:0] {
        S_CODE  = 3'd0,
        S_ARM   = 3'd1,
        S_GUESS = 3'd2,
        S_CLEAR = 3'd3,
        S_CMP   = 3'd4,
        S_JUDGE = 3'd5,
        S_WIN   = 3'd6,
        S_LOSE  = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_GUESSES);
    localparam logic [CNT_W:0]   MAX_WIDE = (CNT_W+1)'(MAX_GUESSES);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       idx;
    logic [1:0]       idx_nxt;
    logic [CNT_W-1:0] guess_count_nxt;

    logic             load_q;
    logic             press_en;
    logic             press;

    logic [CNT_W:0]   count_inc;
    logic             out_of_guesses;
    logic             all_red;

    // The white count is only for the player's display; judging needs red alone.
    logic             unused_white;
    assign unused_white = ^white_in;

    // Rising-edge detect on the load key. press_en stays low for the first cycle after
    // reset so a key held through reset never counts as a fresh press.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            load_q   <= 1'b0;
            press_en <= 1'b0;
        end else begin
            load_q   <= load;
            press_en <= 1'b1;
        end
    end

    assign press = load & ~load_q & press_en;

    // Guess count one wider than the register so the compare against MAX_GUESSES cannot wrap.
    assign count_inc      = {1'b0, guess_count} + {{CNT_W{1'b0}}, 1'b1};
    assign out_of_guesses = (count_inc >= MAX_WIDE);
    assign all_red        = (red_in == 3'd4);

    // FSM state, shared digit/compare index and guess counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_CODE;
            idx         <= 2'd0;
            guess_count <= '0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            guess_count <= guess_count_nxt;
        end
    end

    // Next-state and Moore/press-qualified outputs; every output defaults low.
    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        guess_count_nxt = guess_count;
        load_code       = 4'b0000;
        load_guess      = 4'b0000;
        clear_score     = 1'b0;
        compare_en      = 1'b0;
        compare_i       = 2'd0;
        hide_code       = 1'b0;
        result_valid    = 1'b0;
        won             = 1'b0;
        lost            = 1'b0;

        case (state)
            S_CODE: begin
                if (press) begin
                    load_code = 4'b0001 << idx;
                    idx_nxt   = idx + 2'd1;
                    if (idx == 2'd3) begin
                        state_nxt = S_ARM;
                    end
                end
            end

            S_ARM: begin
                // Hand-over point between code setter and guesser.
                hide_code = 1'b1;
                if (press) begin
                    idx_nxt   = 2'd0;
                    state_nxt = S_GUESS;
                end
            end

            S_GUESS: begin
                hide_code = 1'b1;
                if (press) begin
                    load_guess = 4'b0001 << idx;
                    idx_nxt    = idx + 2'd1;
                    if (idx == 2'd3) begin
                        state_nxt = S_CLEAR;
                    end
                end
            end

            S_CLEAR: begin
                hide_code   = 1'b1;
                clear_score = 1'b1;
                idx_nxt     = 2'd0;
                state_nxt   = S_CMP;
            end

            S_CMP: begin
                // idx doubles as the comparator's code-digit index.
                hide_code  = 1'b1;
                compare_en = 1'b1;
                compare_i  = idx;
                idx_nxt    = idx + 2'd1;
                if (idx == 2'd3) begin
                    state_nxt = S_JUDGE;
                end
            end

            S_JUDGE: begin
                hide_code    = 1'b1;
                result_valid = 1'b1;
                idx_nxt      = 2'd0;
                if (guess_count < MAX_CNT) begin
                    guess_count_nxt = count_inc[CNT_W-1:0];
                end
                // A correct guess wins even when it is the last one allowed.
                if (all_red) begin
                    state_nxt = S_WIN;
                end else if (out_of_guesses) begin
                    state_nxt = S_LOSE;
                end else begin
                    state_nxt = S_GUESS;
                end
            end

            S_WIN, S_LOSE: begin
                won  = (state == S_WIN);
                lost = (state == S_LOSE);
                if (press) begin
                    clear_score     = 1'b1;
                    guess_count_nxt = '0;
                    idx_nxt         = 2'd0;
                    state_nxt       = S_CODE;
                end
            end

            default: begin
                state_nxt = S_CODE;
                idx_nxt   = 2'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Purpose: scoreboard bench for mastermind_game_ctrl; directed games with hand-computed events.
// Latency: each expected event carries the cycle it must appear in.
// Backpressure: n/a; stimulus pushes expectations, a monitor pops on every strobe or probe cycle.
module tb_mastermind_game_ctrl;

    localparam int MAX_G = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       load = 1'b0;
    logic [2:0] red_in = 3'd0;
    logic [2:0] white_in = 3'd0;
    logic [3:0] load_code;
    logic [3:0] load_guess;
    logic       clear_score;
    logic       compare_en;
    logic [1:0] compare_i;
    logic       hide_code;
    logic       result_valid;
    logic [3:0] guess_count;
    logic       won;
    logic       lost;

    mastermind_game_ctrl #(.MAX_GUESSES(MAX_G), .CNT_W(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .load         (load),
        .red_in       (red_in),
        .white_in     (white_in),
        .load_code    (load_code),
        .load_guess   (load_guess),
        .clear_score  (clear_score),
        .compare_en   (compare_en),
        .compare_i    (compare_i),
        .hide_code    (hide_code),
        .result_valid (result_valid),
        .guess_count  (guess_count),
        .won          (won),
        .lost         (lost)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] lc;
        logic [3:0] lg;
        logic       cs;
        logic       ce;
        logic [1:0] ci;
        logic       hide;
        logic       rv;
        logic [3:0] gc;
        logic       won;
        logic       lost;
    } obs_t;

    typedef struct packed {
        logic [31:0] cyc;
        obs_t        o;
    } exp_t;

    exp_t        sb_q[$];
    string       name_q[$];
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_miss = 0;
    logic        probe = 1'b0;
    logic        done = 1'b0;
    logic [3:0]  exp_gc = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t mk(input logic [3:0] lc, input logic [3:0] lg, input logic cs,
                                input logic ce, input logic [1:0] ci, input logic hide,
                                input logic rv, input logic [3:0] gc, input logic w,
                                input logic l);
        obs_t o;
        o.lc = lc; o.lg = lg; o.cs = cs; o.ce = ce; o.ci = ci;
        o.hide = hide; o.rv = rv; o.gc = gc; o.won = w; o.lost = l;
        return o;
    endfunction

    // Monitor: pops one expectation whenever a strobe is seen or the stimulus requests a probe.
    initial begin
        obs_t act;
        exp_t e;
        string nm;
        forever begin
            @(negedge clk);
            if (done || cyc > 20000) begin
                n_vec++;
                if (!done) begin
                    n_miss++;
                    $display("FAIL watchdog: stimulus still running at cyc %0d, required done", cyc);
                end else if (sb_q.size() != 0) begin
                    n_miss++;
                    $display("FAIL drain: %0d events never seen, required 0 (next %s @%0d)",
                             sb_q.size(), name_q[0], sb_q[0].cyc);
                end
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
                $finish;
            end
            act = mk(load_code, load_guess, clear_score, compare_en, compare_i, hide_code,
                     result_valid, guess_count, won, lost);
            if (((|load_code) | (|load_guess) | clear_score | compare_en | result_valid | probe)
                === 1'b1) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected: cyc %0d got %h, required no event", cyc, act);
                end else begin
                    e  = sb_q.pop_front();
                    nm = name_q.pop_front();
                    if (e.cyc != cyc || act !== e.o) begin
                        n_miss++;
                        $display("FAIL %s: cyc %0d got %h, required %h at cyc %0d",
                                 nm, cyc, act, e.o, e.cyc);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int off, input obs_t o, input string nm);
        exp_t e;
        e.cyc = cyc + off;
        e.o   = o;
        sb_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic do_probe(input obs_t o, input string nm);
        push(0, o, nm);
        probe = 1'b1;
        step();
        probe = 1'b0;
    endtask

    // One key push: rises now, held for 'hold' cycles, then released for a cycle.
    task automatic key(input int hold);
        load = 1'b1;
        repeat (hold) step();
        load = 1'b0;
        step();
    endtask

    task automatic enter_code(input int hold);
        for (int i = 0; i < 4; i++) begin
            push(0, mk(4'(1 << i), 4'd0, 0, 0, 2'd0, 0, 0, exp_gc, 0, 0), "load_code");
            key(hold);
        end
    endtask

    // Four guess digits then the clear/compare/judge sequence; optional key chatter meanwhile.
    task automatic guess_round(input logic [2:0] red, input logic [2:0] white, input bit toggle);
        for (int i = 0; i < 3; i++) begin
            push(0, mk(4'd0, 4'(1 << i), 0, 0, 2'd0, 1, 0, exp_gc, 0, 0), "load_guess");
            key(1);
        end
        push(0, mk(4'd0, 4'b1000, 0, 0, 2'd0, 1, 0, exp_gc, 0, 0), "load_guess3");
        push(1, mk(4'd0, 4'd0, 1, 0, 2'd0, 1, 0, exp_gc, 0, 0), "clear_score");
        for (int k = 0; k < 4; k++) begin
            push(2 + k, mk(4'd0, 4'd0, 0, 1, 2'(k), 1, 0, exp_gc, 0, 0), "compare");
        end
        push(6, mk(4'd0, 4'd0, 0, 0, 2'd0, 1, 1, exp_gc, 0, 0), "result_valid");
        load = 1'b1;
        step();
        for (int k = 1; k <= 6; k++) begin
            load = toggle && (k % 2 == 0);
            if (k == 6) begin
                red_in   = red;
                white_in = white;
            end
            step();
        end
        load     = 1'b0;
        red_in   = 3'd0;
        white_in = 3'd0;
        if (exp_gc < 4'(MAX_G)) exp_gc = exp_gc + 4'd1;
        step();
    endtask

    task automatic restart(input logic w, input logic l);
        push(0, mk(4'd0, 4'd0, 1, 0, 2'd0, 0, 0, exp_gc, w, l), "restart");
        key(1);
        exp_gc = 4'd0;
        do_probe(mk(4'd0, 4'd0, 0, 0, 2'd0, 0, 0, 4'd0, 0, 0), "code_after_restart");
    endtask

    initial begin
        resetn = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        do_probe(mk(4'd0, 4'd0, 0, 0, 2'd0, 0, 0, 4'd0, 0, 0), "reset_state");

        // Game 1: long key holds, score 2/1, chatter during compare, win on guess 3.
        enter_code(3);
        do_probe(mk(4'd0, 4'd0, 0, 0, 2'd0, 1, 0, 4'd0, 0, 0), "arm_hidden");
        key(2);
        guess_round(3'd2, 3'd1, 1'b0);
        do_probe(mk(4'd0, 4'd0, 0, 0, 2'd0, 1, 0, 4'd1, 0, 0), "back_in_guess");
        guess_round(3'd0, 3'd3, 1'b1);
        guess_round(3'd4, 3'd0, 1'b0);
        do_probe(mk(4'd0, 4'd0, 0, 0, 2'd0, 0, 0, 4'd3, 1, 0), "win_g3");
        restart(1'b1, 1'b0);

        // Game 2: every round scores one red, lose after the last allowed guess.
        enter_code(1);
        key(1);
        for (int r = 0; r < MAX_G; r++) guess_round(3'd1, 3'd0, 1'b0);
        do_probe(mk(4'd0, 4'd0, 0, 0, 2'd0, 0, 0, 4'd8, 0, 1), "lose_max");
        restart(1'b0, 1'b1);

        // Game 3: correct on the final allowed guess wins rather than loses.
        enter_code(1);
        key(1);
        for (int r = 0; r < MAX_G - 1; r++) guess_round(3'd1, 3'd2, 1'b0);
        guess_round(3'd4, 3'd0, 1'b0);
        do_probe(mk(4'd0, 4'd0, 0, 0, 2'd0, 0, 0, 4'd8, 1, 0), "win_on_last");
        restart(1'b1, 1'b0);

        // Reset during compare step 2 with the key held high.
        enter_code(1);
        key(1);
        for (int i = 0; i < 3; i++) begin
            push(0, mk(4'd0, 4'(1 << i), 0, 0, 2'd0, 1, 0, 4'd0, 0, 0), "rst_load_guess");
            key(1);
        end
        push(0, mk(4'd0, 4'b1000, 0, 0, 2'd0, 1, 0, 4'd0, 0, 0), "rst_load_guess3");
        push(1, mk(4'd0, 4'd0, 1, 0, 2'd0, 1, 0, 4'd0, 0, 0), "rst_clear");
        for (int k = 0; k < 3; k++) begin
            push(2 + k, mk(4'd0, 4'd0, 0, 1, 2'(k), 1, 0, 4'd0, 0, 0), "rst_compare");
        end
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (3) step();
        resetn = 1'b0;
        load   = 1'b1;
        step();
        resetn = 1'b1;
        do_probe(mk(4'd0, 4'd0, 0, 0, 2'd0, 0, 0, 4'd0, 0, 0), "after_mid_reset");
        repeat (4) step();
        load = 1'b0;
        step();
        push(0, mk(4'b0001, 4'd0, 0, 0, 2'd0, 0, 0, 4'd0, 0, 0), "first_press_after_reset");
        key(1);
        do_probe(mk(4'd0, 4'd0, 0, 0, 2'd0, 0, 0, 4'd0, 0, 0), "code_idle");

        repeat (3) step();
        done = 1'b1;
    end

endmodule
